pipe_elastic_reg: RTL and testbench
===================================

// Module: pipe_elastic_reg
// PURPOSE
//  Generic elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a data payload plus a control payload through DEPTH chained stages.
//  Each stage has its own valid bit and valid/ready backpressure, so stalls hold state and bubbles close up.
//  Flush squashes all in-flight entries; squashed control fields always read as zero (no side effects).
// PARAMETERS
//  DATA_W      64  width of data payload (buses, PC, immediate, register ids)
//  CTRL_W      16  width of control payload (regwrite, memread, memwrite, branch, aluctrl...); zeroed on bubble
//  DEPTH       1   number of register stages, 1..8
//  ZERO_DATA   1   1: data payload also zeroed on reset/flush/empty stage; 0: data left unchanged
// PORTS
//  clk         in   1                   rising-edge clock
//  resetl      in   1                   asynchronous active-low reset
//  flush       in   1                   squash all stages and any input accepted this cycle
//  in_valid    in   1                   upstream entry present
//  in_ready    out  1                   stage 0 can accept; = adv[0] & !flush
//  in_data     in   DATA_W              upstream data payload
//  in_ctrl     in   CTRL_W              upstream control payload
//  out_valid   out  1                   valid[DEPTH-1]
//  out_ready   in   1                   downstream accepts (0 = stall)
//  out_data    out  DATA_W              data[DEPTH-1]
//  out_ctrl    out  CTRL_W              ctrl[DEPTH-1]; always 0 when out_valid=0
//  occupancy   out  $clog2(DEPTH+1)     number of stages holding a valid entry
// BEHAVIOUR
//  Reset (resetl=0, async, takes effect immediately):
//   - all valid=0, all ctrl=0, data=0 (data cleared regardless of ZERO_DATA).
//   - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 while in reset.
//  Advance chain (combinational):
//   - adv[DEPTH-1] = !valid[DEPTH-1] | out_ready
//   - adv[i] = !valid[i] | adv[i+1]
//   - out_ready is allowed to depend on out_valid; in_ready depends on out_ready combinationally.
//  Per-stage update on rising clk when flush=0:
//   - if adv[i]: stage i loads stage i-1 (stage 0 loads in_*); valid[i] <= source valid.
//   - if source not valid: ctrl[i] <= 0; data[i] <= 0 if ZERO_DATA, else hold.
//   - if !adv[i]: hold valid, ctrl, data (stall).
//  Flush (flush=1 at a clock edge): all valid<=0, all ctrl<=0, data zeroed if ZERO_DATA.
//   - flush beats stall and beats in_valid; the entry on in_* that cycle is dropped (in_ready=0).
//   - the output entry is not consumed by flush: if out_valid & out_ready in the flush cycle,
//     the downstream handshake completes; the entry is then cleared.
//  Transfer rules:
//   - input transfer iff in_valid & in_ready; output transfer iff out_valid & out_ready.
//   - in_data/in_ctrl ignored when in_valid=0.
//  Timing:
//   - latency DEPTH cycles from input transfer to out_valid when out_ready=1.
//   - throughput 1 entry/cycle; no bubbles inserted under continuous flow.
//   - a bubble in stage i is filled the same cycle the upstream stage advances (bubble collapse).
//  occupancy:
//   - registered popcount of valid[]; range 0..DEPTH.
//   - full: occupancy=DEPTH with out_ready=0 -> in_ready=0.
//   - simultaneous in/out transfer at full: occupancy unchanged, no data lost.
//  Ordering: strict FIFO; no entry is duplicated, reordered or dropped except by flush.
//  DEPTH=1 with out_ready tied 1 behaves as a plain bubble/reset register (in_valid=0 acts as bubble).
// TESTING
//  T1 DEPTH=1, out_ready=1, in_valid=1, data=0xA5, ctrl=0x3 -> next edge: out_valid=1, out_data=0xA5, out_ctrl=0x3, occupancy=1.
//  T2 DEPTH=3, stream 0x1..0x6 with out_ready=1 -> out 0x1 after 3 edges, then one per cycle in order, no gaps.
//  T3 DEPTH=3, out_ready=0 for 5 cycles while streaming -> occupancy 3, in_ready=0; release -> 0x1,0x2,0x3 in order, none lost.
//  T4 DEPTH=3, full, flush=1 with in_valid=1 -> next edge: out_valid=0, out_ctrl=0, occupancy=0; flushed input never emerges.
//  T5 DEPTH=2, bubble at stage 1, out_ready=0 -> stage 0 entry advances into stage 1; occupancy 1->2 with in_ready held 1.
//  T6 resetl driven low mid-stream, asynchronous to clk -> outputs 0 immediately; after release, first new input exits after DEPTH edges.

Source files
------------

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: DEPTH chained valid/ready stages carrying data + control.
// Bubbles collapse, stalls hold, flush squashes everything with control zeroed.
module pipe_elastic_reg #(
    parameter int DATA_W    = 64,
    parameter int CTRL_W    = 16,
    parameter int DEPTH     = 1,
    parameter int ZERO_DATA = 1
) (
    input  logic                         clk,
    input  logic                         resetl,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [OW-1:0]     r_occ;

    logic [DEPTH-1:0]  w_adv;
    logic [DEPTH-1:0]  w_src_valid;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [DATA_W-1:0] w_src_data [DEPTH];
    logic [CTRL_W-1:0] w_src_ctrl [DEPTH];
    logic [OW-1:0]     w_occ_nxt;

    // Stage i may move when any stage from i to the tail has a hole, or the sink drains.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_adv[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                w_adv[i] = w_adv[i] | ~r_valid[j];
            end
        end
    end

    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_data[0]  = in_data;
        w_src_ctrl[0]  = in_ctrl;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_data[i]  = r_data[i-1];
            w_src_ctrl[i]  = r_ctrl[i-1];
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        w_occ_nxt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                w_valid_nxt[i] = 1'b0;
            end else if (w_adv[i]) begin
                w_valid_nxt[i] = w_src_valid[i];
            end
            w_occ_nxt = w_occ_nxt + OW'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_ctrl[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (flush || (w_adv[i] && !w_src_valid[i])) begin
                    r_ctrl[i] <= '0;
                    if (ZERO_DATA != 0) begin
                        r_data[i] <= '0;
                    end
                end else if (w_adv[i]) begin
                    r_data[i] <= w_src_data[i];
                    r_ctrl[i] <= w_src_ctrl[i];
                end
            end
        end
    end

    // Gated by resetl so nothing is accepted while reset is held.
    assign in_ready  = w_adv[0] & ~flush & resetl;
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign out_ctrl  = r_ctrl[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg at DEPTH 1, 2 and 3.
// Stall, flush, bubble collapse and async reset with hand-computed expectations.
module tb_pipe_elastic_reg;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam logic [1:0] OCC_T2 [9] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3,
                                          2'd3, 2'd2, 2'd1, 2'd0};

    logic clk = 1'b0;
    logic resetl = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic          f1 = 0, iv1 = 0, or1 = 1, ir1, ov1;
    logic [DW-1:0] id1 = '0, od1;
    logic [CW-1:0] ic1 = '0, oc1;
    logic          occ1;

    logic          f2 = 0, iv2 = 0, or2 = 1, ir2, ov2;
    logic [DW-1:0] id2 = '0, od2;
    logic [CW-1:0] ic2 = '0, oc2;
    logic [1:0]    occ2;

    logic          f3 = 0, iv3 = 0, or3 = 1, ir3, ov3;
    logic [DW-1:0] id3 = '0, od3;
    logic [CW-1:0] ic3 = '0, oc3;
    logic [1:0]    occ3;

    always #5 clk = ~clk;

    pipe_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .ZERO_DATA(1)) u_d1 (
        .clk(clk), .resetl(resetl), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_ctrl(ic1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1)
    );

    pipe_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .ZERO_DATA(1)) u_d2 (
        .clk(clk), .resetl(resetl), .flush(f2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_ctrl(ic2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ctrl(oc2),
        .occupancy(occ2)
    );

    pipe_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .ZERO_DATA(1)) u_d3 (
        .clk(clk), .resetl(resetl), .flush(f3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3), .in_ctrl(ic3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_ctrl(oc3),
        .occupancy(occ3)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, with an input offered to show in_ready stays low
        iv3 = 1; id3 = 16'h99; ic3 = 8'h99;
        #12;
        check("rst_ov", ov3, 0);
        check("rst_od", od3, 0);
        check("rst_oc", oc3, 0);
        check("rst_occ", occ3, 0);
        check("rst_ir", ir3, 0);
        check("rst_ir1", ir1, 0);
        iv3 = 0;
        #10 resetl = 1;
        tick;

        // T1: DEPTH=1 single transfer then bubble
        iv1 = 1; id1 = 16'hA5; ic1 = 8'h03; or1 = 1;
        tick;
        check("t1_ov", ov1, 1);
        check("t1_od", od1, 16'hA5);
        check("t1_oc", oc1, 8'h03);
        check("t1_occ", occ1, 1);
        iv1 = 0;
        tick;
        check("t1_bub_ov", ov1, 0);
        check("t1_bub_oc", oc1, 0);
        check("t1_bub_od", od1, 0);
        check("t1_bub_occ", occ1, 0);

        // T2: DEPTH=3 stream 1..6, free flowing
        or3 = 1;
        for (int c = 0; c < 9; c++) begin
            iv3 = (c < 6);
            id3 = DW'(c + 1);
            ic3 = CW'(c + 16);
            #1;
            check("t2_ir", ir3, 1);
            tick;
            if (c >= 2 && c <= 7) begin
                check("t2_ov", ov3, 1);
                check("t2_od", od3, 64'(c - 1));
                check("t2_oc", oc3, 64'(c - 2 + 16));
            end else begin
                check("t2_ov0", ov3, 0);
                check("t2_oc0", oc3, 0);
            end
            check("t2_occ", occ3, OCC_T2[c]);
        end

        // T3: stall until full, then release with simultaneous in/out
        or3 = 0; iv3 = 1;
        id3 = 16'h11; ic3 = 8'h81; tick;
        id3 = 16'h12; ic3 = 8'h82; tick;
        id3 = 16'h13; ic3 = 8'h83; tick;
        check("t3_full_occ", occ3, 3);
        check("t3_full_ov", ov3, 1);
        check("t3_full_od", od3, 16'h11);
        check("t3_full_oc", oc3, 8'h81);
        id3 = 16'h14; ic3 = 8'h84;
        #1;
        check("t3_full_ir", ir3, 0);
        tick;
        tick;
        check("t3_hold_occ", occ3, 3);
        check("t3_hold_od", od3, 16'h11);
        check("t3_hold_ir", ir3, 0);
        or3 = 1;
        #1;
        check("t3_rel_ir", ir3, 1);
        tick;
        check("t3_io_od", od3, 16'h12);
        check("t3_io_oc", oc3, 8'h82);
        check("t3_io_occ", occ3, 3);
        iv3 = 0;
        tick;
        check("t3_d13", od3, 16'h13);
        check("t3_occ2", occ3, 2);
        tick;
        check("t3_d14", od3, 16'h14);
        check("t3_c14", oc3, 8'h84);
        check("t3_occ1", occ3, 1);
        tick;
        check("t3_empty_ov", ov3, 0);
        check("t3_empty_occ", occ3, 0);

        // T4: flush a full pipe while offering an input
        or3 = 0; iv3 = 1;
        id3 = 16'h21; ic3 = 8'hA1; tick;
        id3 = 16'h22; ic3 = 8'hA2; tick;
        id3 = 16'h23; ic3 = 8'hA3; tick;
        check("t4_full_occ", occ3, 3);
        f3 = 1; id3 = 16'h24; ic3 = 8'hA4;
        #1;
        check("t4_fl_ir", ir3, 0);
        tick;
        f3 = 0; iv3 = 0;
        check("t4_ov", ov3, 0);
        check("t4_oc", oc3, 0);
        check("t4_od", od3, 0);
        check("t4_occ", occ3, 0);
        or3 = 1;
        tick;
        tick;
        tick;
        check("t4_gone_ov", ov3, 0);
        check("t4_gone_occ", occ3, 0);

        // T5: DEPTH=2 bubble in stage 1 closes up under stall
        or2 = 1; iv2 = 1; id2 = 16'h31; ic2 = 8'hB1;
        tick;
        check("t5_occ1", occ2, 1);
        check("t5_ov0", ov2, 0);
        or2 = 0; id2 = 16'h32; ic2 = 8'hB2;
        #1;
        check("t5_ir", ir2, 1);
        tick;
        check("t5_occ2", occ2, 2);
        check("t5_ov", ov2, 1);
        check("t5_od", od2, 16'h31);
        iv2 = 0;
        #1;
        check("t5_full_ir", ir2, 0);
        or2 = 1;
        tick;
        check("t5_d32", od2, 16'h32);
        check("t5_c32", oc2, 8'hB2);
        check("t5_occ_dn", occ2, 1);
        tick;
        check("t5_empty", ov2, 0);

        // T6: async reset mid-stream
        or3 = 1; iv3 = 1;
        id3 = 16'h41; ic3 = 8'hC1; tick;
        id3 = 16'h42; ic3 = 8'hC2; tick;
        id3 = 16'h43; ic3 = 8'hC3; tick;
        check("t6_pre_od", od3, 16'h41);
        #3;
        resetl = 0;
        #1;
        check("t6_ov", ov3, 0);
        check("t6_od", od3, 0);
        check("t6_oc", oc3, 0);
        check("t6_occ", occ3, 0);
        check("t6_ir", ir3, 0);
        id3 = 16'h51; ic3 = 8'hD1;
        #3;
        resetl = 1;
        tick;
        iv3 = 0;
        check("t6_e1", ov3, 0);
        tick;
        check("t6_e2", ov3, 0);
        tick;
        check("t6_e3_ov", ov3, 1);
        check("t6_e3_od", od3, 16'h51);
        check("t6_e3_oc", oc3, 8'hD1);
        tick;
        check("t6_after", ov3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
